// File: rtl/hazard_ctrl.sv
// D-stage hazard/forwarding controller: E/M/W shadow tracking, bypass selects, stall and mult/div busy.
// Latency: selects and stall are combinational from shadows; shadows and busy counter update each clk edge.
// Backpressure: stall_D freezes PC/F-D and bubbles E; HAZARD_STATS_EN adds a stall-cycle counter.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  Rs_D,
  input  logic [4:0]  Rt_D,
  input  logic [1:0]  tuse_rs_D,
  input  logic [1:0]  tuse_rt_D,
  input  logic [4:0]  wr_reg_D,
  input  logic [1:0]  tnew_D,
  input  logic [1:0]  kind_D,
  input  logic        md_op_D,
  input  logic        md_start_E,
  input  logic        md_div_E,
  input  logic        flush,
  output logic [2:0]  RS_Dforward,
  output logic [2:0]  RT_Dforward,
  output logic        stall_D,
  output logic        md_busy,
  output logic [31:0] stall_count
);

  typedef enum logic [1:0] {
    KIND_ALU  = 2'd0,
    KIND_MEM  = 2'd1,
    KIND_PC8  = 2'd2,
    KIND_LOHI = 2'd3
  } kind_e;

  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
    kind_e      kind;
  } shadow_t;

  typedef struct packed {
    logic       stall;
    logic [2:0] sel;
  } src_res_t;

  localparam shadow_t BUBBLE  = '0;
  localparam int      MD_MAX  = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int      MD_W    = $clog2(MD_MAX + 1);

  localparam logic [2:0] SEL_NONE  = 3'd0;
  localparam logic [2:0] SEL_M_ALU = 3'd1;
  localparam logic [2:0] SEL_E_PC8 = 3'd2;
  localparam logic [2:0] SEL_M_PC8 = 3'd3;
  localparam logic [2:0] SEL_M_HL  = 3'd4;

  shadow_t           e_q, m_q, w_q;
  shadow_t           d_entry;
  logic [MD_W-1:0]   md_cnt_q;
  logic              md_busy_int;
  logic              md_stall;
  logic              data_stall;
  logic              stall_int;
  src_res_t          rs_res, rt_res;

  // Ages an entry one stage down the pipe; tnew saturates at zero.
  function automatic shadow_t age(input shadow_t s);
    shadow_t r;
    r = s;
    if (s.tnew != 2'd0) begin
      r.tnew = s.tnew - 2'd1;
    end
    return r;
  endfunction

  // First match wins (E, then M); a W match needs no bypass since the GRF writes through.
  function automatic src_res_t resolve(input logic [4:0] src, input logic [1:0] tuse,
                                       input shadow_t e, input shadow_t m);
    src_res_t r;
    r = '0;
    if (tuse != 2'd3 && src != 5'd0) begin
      if (src == e.dst) begin
        r.sel   = (e.kind == KIND_PC8) ? SEL_E_PC8 : SEL_NONE;
        r.stall = (e.tnew > tuse);
      end else if (src == m.dst) begin
        case (m.kind)
          KIND_ALU:  r.sel = SEL_M_ALU;
          KIND_PC8:  r.sel = SEL_M_PC8;
          KIND_LOHI: r.sel = SEL_M_HL;
          default:   r.sel = SEL_NONE;
        endcase
        r.stall = (m.tnew > tuse);
      end
    end
    return r;
  endfunction

  assign d_entry = '{dst: wr_reg_D, tnew: tnew_D, kind: kind_e'(kind_D)};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q <= BUBBLE;
      m_q <= BUBBLE;
      w_q <= BUBBLE;
    end else begin
      e_q <= (flush || stall_int) ? BUBBLE : d_entry;
      m_q <= age(e_q);
      w_q <= age(m_q);
    end
  end

  // A started unit always runs to completion; flush leaves the counter alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_cnt_q <= '0;
    end else if (md_start_E) begin
      md_cnt_q <= md_div_E ? MD_W'(DIV_CYCLES) : MD_W'(MULT_CYCLES);
    end else if (md_cnt_q != '0) begin
      md_cnt_q <= md_cnt_q - MD_W'(1);
    end
  end

  always_comb begin
    rs_res      = resolve(Rs_D, tuse_rs_D, e_q, m_q);
    rt_res      = resolve(Rt_D, tuse_rt_D, e_q, m_q);
    md_busy_int = (md_cnt_q != '0);
    md_stall    = md_op_D && (md_busy_int || md_start_E);
    data_stall  = rs_res.stall || rt_res.stall;
    stall_int   = data_stall || md_stall;
  end

  // Outputs are forced low while reset is held, independent of the D-stage inputs.
  assign RS_Dforward = reset ? rs_res.sel : 3'd0;
  assign RT_Dforward = reset ? rt_res.sel : 3'd0;
  assign stall_D     = reset & stall_int;
  assign md_busy     = reset & md_busy_int;

  logic unused_w;
  assign unused_w = ^w_q;

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= 32'd0;
    end else if (stall_D) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl; expectations queued by stimulus, compared by a negedge monitor.
// Latency: one vector per clock; backpressure: none, stall_D is only observed.
// Stall counter expectations follow HAZARD_STATS_EN.
module tb_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  Rs_D, Rt_D, wr_reg_D;
  logic [1:0]  tuse_rs_D, tuse_rt_D, tnew_D, kind_D;
  logic        md_op_D, md_start_E, md_div_E, flush;
  logic [2:0]  RS_Dforward, RT_Dforward;
  logic        stall_D, md_busy;
  logic [31:0] stall_count;

  hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset),
    .Rs_D(Rs_D), .Rt_D(Rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .wr_reg_D(wr_reg_D), .tnew_D(tnew_D), .kind_D(kind_D),
    .md_op_D(md_op_D), .md_start_E(md_start_E), .md_div_E(md_div_E), .flush(flush),
    .RS_Dforward(RS_Dforward), .RT_Dforward(RT_Dforward),
    .stall_D(stall_D), .md_busy(md_busy), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic        stall;
    logic        busy;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_err    = 0;
  int   model_stalls = 0;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s.%s: got %0h, expected %0h", nm, fld, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      chk(mon_e.name, "rs_fwd", 32'(RS_Dforward), 32'(mon_e.rs));
      chk(mon_e.name, "rt_fwd", 32'(RT_Dforward), 32'(mon_e.rt));
      chk(mon_e.name, "stall",  32'(stall_D),     32'(mon_e.stall));
      chk(mon_e.name, "busy",   32'(md_busy),     32'(mon_e.busy));
      chk(mon_e.name, "cnt",    stall_count,      mon_e.cnt);
    end
  end

  // Drives one D-stage vector after the edge, queues its expected outputs, then advances a cycle.
  task automatic vec(input string nm,
                     input int rs, input int tus, input int rt, input int tut,
                     input int wr, input int tn, input int kd,
                     input int mdop, input int mds, input int mdd, input int fl,
                     input int ers, input int ert, input int est, input int ebusy);
    exp_t e;
    Rs_D = 5'(rs);  tuse_rs_D = 2'(tus);
    Rt_D = 5'(rt);  tuse_rt_D = 2'(tut);
    wr_reg_D = 5'(wr); tnew_D = 2'(tn); kind_D = 2'(kd);
    md_op_D = 1'(mdop); md_start_E = 1'(mds); md_div_E = 1'(mdd); flush = 1'(fl);
    if (!reset) model_stalls = 0;
    e.name  = nm;
    e.rs    = 3'(ers);
    e.rt    = 3'(ert);
    e.stall = 1'(est);
    e.busy  = 1'(ebusy);
`ifdef HAZARD_STATS_EN
    e.cnt   = 32'(model_stalls);
`else
    e.cnt   = 32'd0;
`endif
    if (est != 0) model_stalls++;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    n_err++;
    $display("FAIL timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    reset = 1'b0;
    Rs_D = '0; Rt_D = '0; tuse_rs_D = 2'd3; tuse_rt_D = 2'd3;
    wr_reg_D = '0; tnew_D = '0; kind_D = '0;
    md_op_D = 0; md_start_E = 0; md_div_E = 0; flush = 0;
    @(posedge clk); #1;
    //   name        rs tus rt tut wr tn kd mdop mds mdd fl  ers ert est busy
    vec("rst_idle",   0, 3, 0, 3,  0, 0, 0, 0,  0,  0,  0,  0,  0,  0,  0);
    vec("rst_gate",   0, 3, 0, 3,  0, 0, 0, 1,  1,  1,  0,  0,  0,  0,  0);
    reset = 1'b1;
    vec("addu3",      0, 3, 0, 3,  3, 1, 0, 0,  0,  0,  0,  0,  0,  0,  0);
    vec("use3_e",     3, 0, 0, 3,  4, 1, 0, 0,  0,  0,  0,  0,  0,  1,  0);
    vec("use3_m",     3, 0, 0, 3,  4, 1, 0, 0,  0,  0,  0,  1,  0,  0,  0);
    vec("lw5",        4, 1, 0, 3,  5, 2, 1, 0,  0,  0,  0,  0,  0,  0,  0);
    vec("beq_e",      4, 0, 5, 0,  0, 0, 0, 0,  0,  0,  0,  1,  0,  1,  0);
    vec("beq_m",      4, 0, 5, 0,  0, 0, 0, 0,  0,  0,  0,  0,  0,  1,  0);
    vec("beq_w",      4, 0, 5, 0,  0, 0, 0, 0,  0,  0,  0,  0,  0,  0,  0);
    vec("jal",        0, 3, 0, 3, 31, 0, 2, 0,  0,  0,  0,  0,  0,  0,  0);
    vec("jr_e",      31, 0,31, 3,  0, 0, 0, 0,  0,  0,  0,  2,  0,  0,  0);
    vec("jr_m",      31, 0,31, 1,  0, 0, 0, 0,  0,  0,  0,  3,  3,  0,  0);
    vec("flush",     31, 0, 0, 3,  7, 2, 1, 0,  0,  0,  1,  0,  0,  0,  0);
    vec("post_fl",    7, 0, 7, 0,  0, 0, 0, 0,  0,  0,  0,  0,  0,  0,  0);
    vec("lw8",        0, 3, 0, 3,  8, 2, 1, 0,  0,  0,  0,  0,  0,  0,  0);
    vec("fl_stall",   8, 0, 0, 3,  9, 2, 1, 0,  0,  0,  1,  0,  0,  1,  0);
    vec("post_fl2",   9, 0, 0, 3,  0, 0, 0, 0,  0,  0,  0,  0,  0,  0,  0);
    vec("r0_prod",    0, 3, 0, 3,  0, 2, 2, 0,  0,  0,  0,  0,  0,  0,  0);
    vec("r0_use",     0, 0, 0, 0, 10, 1, 3, 0,  0,  0,  0,  0,  0,  0,  0);
    vec("lohi_e",    10, 1, 0, 3,  0, 0, 0, 0,  0,  0,  0,  0,  0,  0,  0);
    vec("lohi_m",    10, 0,10, 0,  0, 0, 0, 0,  0,  0,  0,  4,  4,  0,  0);
    vec("div_go",     0, 3, 0, 3,  0, 0, 0, 1,  1,  1,  0,  0,  0,  1,  0);
    for (int i = 0; i < 10; i++)
      vec("div_busy", 0, 3, 0, 3,  0, 0, 0, 1,  0,  0,  0,  0,  0,  1,  1);
    vec("div_done",   0, 3, 0, 3,  0, 0, 0, 1,  0,  0,  0,  0,  0,  0,  0);
    vec("mult_go",    0, 3, 0, 3,  0, 0, 0, 0,  1,  0,  0,  0,  0,  0,  0);
    for (int i = 0; i < 5; i++)
      vec("mult_busy",0, 3, 0, 3,  0, 0, 0, 0,  0,  0,  0,  0,  0,  0,  1);
    vec("mult_done",  0, 3, 0, 3,  0, 0, 0, 0,  0,  0,  0,  0,  0,  0,  0);
    vec("div2_go",    0, 3, 0, 3,  0, 0, 0, 1,  1,  1,  0,  0,  0,  1,  0);
    vec("div2_busy",  0, 3, 0, 3,  0, 0, 0, 1,  0,  0,  0,  0,  0,  1,  1);
    reset = 1'b0;
    vec("rst_mid",    0, 3, 0, 3,  0, 0, 0, 1,  0,  0,  0,  0,  0,  0,  0);
    reset = 1'b1;
    vec("rst_rel",    0, 3, 0, 3,  0, 0, 0, 1,  0,  0,  0,  0,  0,  0,  0);
    @(posedge clk); #1;
    chk("drain", "queue", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
